// File: rtl/rocketcpu_param_smoother.sv
// rocketcpu_param_smoother: per-sample slew limiter for CPU-written audio parameters.
// One shared subtract/shift/add datapath visits one channel per clock after each strobe.
module rocketcpu_param_smoother #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      i_wb_clk,
    input  logic                      i_wb_rst,
    input  logic                      i_sample_strobe,
    input  logic [CHANNELS*WIDTH-1:0] i_target,
    input  logic [4:0]                i_rate,
    output logic [CHANNELS*WIDTH-1:0] o_value,
    output logic [CHANNELS-1:0]       o_settled,
    output logic                      o_busy,
    output logic                      o_overrun
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_busy;
    logic                  r_overrun;
    logic [WIDTH-1:0]      r_val [CHANNELS];
    logic [CHANNELS-1:0]   r_settled;

    logic [WIDTH-1:0]      w_tgt_arr [CHANNELS];
    logic [WIDTH-1:0]      w_tgt;
    logic [WIDTH-1:0]      w_cur;
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH:0] w_shift;
    logic signed [WIDTH:0] w_step;
    logic [WIDTH-1:0]      w_new;
    logic                  w_last;
    logic                  w_force_one;

    // Unpack the flat target bus and repack the value registers.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
        assign w_tgt_arr[k]                = i_target[k*WIDTH +: WIDTH];
        assign o_value[k*WIDTH +: WIDTH]   = r_val[k];
    end

    assign o_settled = r_settled;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

    // Shared slew datapath for the channel selected by r_idx.
    always_comb begin
        w_tgt       = w_tgt_arr[r_idx];
        w_cur       = r_val[r_idx];
        w_diff      = $signed({1'b0, w_tgt}) - $signed({1'b0, w_cur});
        w_shift     = w_diff >>> i_rate;
        // A small positive gap floors to zero; nudge by one so it still converges.
        w_force_one = !w_diff[WIDTH] && (|w_diff) && !(|w_shift);
        w_step      = w_force_one ? {{WIDTH{1'b0}}, 1'b1} : w_shift;
        w_new       = w_cur + w_step[WIDTH-1:0];
        w_last      = (r_idx == IW'(CHANNELS - 1));
    end

    // Pass sequencer: strobe starts a pass, one channel updated per clock.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_settled <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_val[k] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_overrun <= 1'b0;
                    r_idx     <= '0;
                    if (i_sample_strobe) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_overrun        <= i_sample_strobe;
                    r_val[r_idx]     <= w_new;
                    r_settled[r_idx] <= (w_new == w_tgt);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rocketcpu_param_smoother.sv
// tb_rocketcpu_param_smoother: scoreboard bench for the parameter smoother.
// Expected pass results are queued at strobe time and checked when busy falls.
module tb_rocketcpu_param_smoother;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            strobe;
    logic [CH*W-1:0] target;
    logic [4:0]      rate;
    logic [CH*W-1:0] value;
    logic [CH-1:0]   settled;
    logic            busy;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CH*W-1:0] val;
        logic [CH-1:0]   set;
    } exp_t;

    exp_t        q[$];
    logic [W-1:0] m_val [CH];
    logic         prev_busy = 1'b0;

    rocketcpu_param_smoother #(.CHANNELS(CH), .WIDTH(W)) dut (
        .i_wb_clk       (clk),
        .i_wb_rst       (rst),
        .i_sample_strobe(strobe),
        .i_target       (target),
        .i_rate         (rate),
        .o_value        (value),
        .o_settled      (settled),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CH*W-1:0] obs,
                       input logic [CH*W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] v,
                                                input logic [W-1:0] t,
                                                input int r);
        longint d;
        longint s;
        d = longint'(t) - longint'(v);
        if (d > 0) begin
            s = d / (64'sd1 <<< r);
            if (s == 0) s = 1;
        end else if (d < 0) begin
            s = -((-d + (64'sd1 <<< r) - 1) / (64'sd1 <<< r));
        end else begin
            s = 0;
        end
        return W'(longint'(v) + s);
    endfunction

    task automatic push_pass();
        exp_t e;
        for (int k = 0; k < CH; k++) begin
            m_val[k] = model_step(m_val[k], target[k*W +: W], int'(rate));
            e.val[k*W +: W] = m_val[k];
            e.set[k] = (m_val[k] == target[k*W +: W]);
        end
        q.push_back(e);
    endtask

    task automatic do_reset();
        q.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < CH; k++) m_val[k] = '0;
    endtask

    task automatic run_pass(input int gap);
        int n;
        push_pass();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        if (busy) chk("busy_timeout", {127'd0, busy}, '0);
        for (int i = n + 1; i < gap; i++) tick();
    endtask

    // Scoreboard: compare queued result when a pass completes.
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy && !rst && q.size() > 0) begin
            e = q.pop_front();
            chk("pass_val", value, e.val);
            chk("pass_set", {{(CH*W-CH){1'b0}}, settled}, {{(CH*W-CH){1'b0}}, e.set});
        end
        prev_busy = busy;
    end

    initial begin
        logic [W-1:0] up_tbl [17];
        logic [W-1:0] prev;
        int bcnt;
        up_tbl = '{25, 43, 57, 67, 75, 81, 85, 88, 91, 93, 94, 95, 96,
                   97, 98, 99, 100};
        strobe = 1'b0;
        target = {$urandom(), $urandom(), $urandom(), $urandom()};
        rate   = 5'd7;
        strobe = 1'b1;
        do_reset();
        strobe = 1'b0;
        chk("rst_val", value, '0);
        chk("rst_set", {124'd0, settled}, '0);
        chk("rst_busy", {127'd0, busy}, '0);
        chk("rst_ovr", {127'd0, overrun}, '0);

        // Immediate jump.
        target = '0;
        target[W-1:0] = 32'd1000;
        rate = 5'd0;
        push_pass();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("jump_busy0", {127'd0, busy}, 128'd1);
        tick();
        chk("jump_v0", {96'd0, value[W-1:0]}, 128'd1000);
        bcnt = 1;
        for (int i = 0; i < 8; i++) begin
            if (busy) bcnt++;
            tick();
        end
        chk("jump_busy_len", 128'(bcnt), 128'd4);
        chk("jump_set", {124'd0, settled}, 128'hF);

        // Upward glide.
        do_reset();
        target = '0;
        target[W-1:0] = 32'd100;
        rate = 5'd2;
        for (int i = 0; i < 19; i++) begin
            run_pass(16);
            chk("up_seq", {96'd0, value[W-1:0]},
                {96'd0, up_tbl[(i < 17) ? i : 16]});
            chk("up_set0", {127'd0, settled[0]}, {127'd0, (i >= 16)});
        end

        // Downward glide.
        target[W-1:0] = 32'd0;
        prev = value[W-1:0];
        for (int i = 0; i < 40 && prev != 0; i++) begin
            run_pass(8);
            if (i == 0) chk("down_first", {96'd0, value[W-1:0]}, 128'd75);
            if (i == 1) chk("down_second", {96'd0, value[W-1:0]}, 128'd56);
            if (value[W-1:0] > prev)
                chk("down_mono", {96'd0, value[W-1:0]}, {96'd0, prev});
            prev = value[W-1:0];
        end
        chk("down_end", {96'd0, value[W-1:0]}, '0);

        // Full range and overrun.
        do_reset();
        target = {32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        rate = 5'd1;
        push_pass();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("ovr_pulse", {127'd0, overrun}, 128'd1);
        tick();
        chk("ovr_clear", {127'd0, overrun}, '0);
        for (int i = 0; i < 6; i++) tick();
        chk("full_v0", {96'd0, value[W-1:0]}, 128'h7FFF_FFFF);
        chk("idle_after", {127'd0, busy}, '0);

        // Reset mid-pass.
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        q.delete();
        rst = 1'b1;
        tick();
        chk("mid_rst_val", value, '0);
        chk("mid_rst_busy", {127'd0, busy}, '0);
        rst = 1'b0;
        for (int k = 0; k < CH; k++) m_val[k] = '0;
        tick();
        run_pass(8);
        chk("post_rst_v0", {96'd0, value[W-1:0]}, 128'h7FFF_FFFF);

        tick();
        chk("q_drained", 128'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
